word_stacker: RTL and testbench
===============================

WORD_STACKER -- requirements
Module: word_stacker

Interface
REQ-001 SHALL have parameter NARROW_W, default 32, width of each input word in bits.
REQ-002 SHALL have parameter RATIO, default 4, number of input words per output word; legal range 2..16.
REQ-003 SHALL have parameter ORDER, default 0, lane order: 0 puts the first word at the LSB lane, 1 puts it at the MSB lane.
REQ-004 SHALL have port clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous reset, active-high.
REQ-006 SHALL have port clr_i  in  1  synchronous soft clear, active-high.
REQ-007 SHALL have port enable_i  in  1  when low, no input is accepted and fill state is frozen.
REQ-008 SHALL have port flush_i  in  1  closes a partially filled word.
REQ-009 SHALL have port valid_i  in  1  input word valid.
REQ-010 SHALL have port ready_o  out  1  input word accepted when valid_i&ready_o.
REQ-011 SHALL have port word_i  in  NARROW_W  input word.
REQ-012 SHALL have port valid_o  out  1  output word valid.
REQ-013 SHALL have port ready_i  in  1  downstream ready; transfer occurs when valid_o&ready_i.
REQ-014 SHALL have port word_o  out  NARROW_W*RATIO  stacked output word.
REQ-015 SHALL have port strb_o  out  RATIO  one bit per lane; bit is set when that lane holds real data.

Function
REQ-016 SHALL hold input words in an accumulator with a lane count cnt (0..RATIO-1), plus one output register driving valid_o, word_o and strb_o.
REQ-017 SHALL place accepted word k in lane k when ORDER=0 and in lane RATIO-1-k when ORDER=1; lane k occupies bits [k*NARROW_W +: NARROW_W].
REQ-018 SHALL use two FSM states: FILL (accepting words) and FULL (accumulator closed, waiting for the output slot).
REQ-019 SHALL drive ready_o = enable_i & (state==FILL) & ~rst_i & ~clr_i.
REQ-020 SHALL close the accumulator when the RATIO-th word is accepted, or when flush_i&enable_i is high and either cnt>0 or a word is accepted in the same cycle; a word accepted in the flush cycle is included.
REQ-021 SHALL ignore flush_i when cnt==0 and no word is accepted: no output is produced.
REQ-022 SHALL define the output slot as free when ~valid_o | ready_i.
REQ-023 SHALL, on close with the slot free, load the output register at that same edge: valid_o is high in the cycle after the closing accept (latency 1 cycle); cnt returns to 0 and the state stays FILL.
REQ-024 SHALL, on close with the slot not free, move to FULL; in FULL, transfer to the output register on the first edge where the slot is free, then return to FILL with cnt=0.
REQ-025 SHALL zero unfilled lanes of word_o and clear their strb_o bits; a complete word has strb_o all ones.
REQ-026 SHALL clear valid_o on an edge where valid_o&ready_i and no new word is loaded; back-to-back loads SHALL sustain one output word per RATIO input cycles with no bubble.
REQ-027 SHALL hold word_o and strb_o stable while valid_o is high and ready_i is low.
REQ-028 SHALL let the output handshake complete while enable_i is low; FULL-to-output transfers SHALL also proceed with enable_i low.
REQ-029 SHALL give clr_i the same effect as reset, with reset taking priority over clr_i and clr_i taking priority over all other inputs.

Reset
REQ-030 SHALL, while rst_i is high at an edge, set valid_o=0, word_o=0, strb_o=0, cnt=0, clear the accumulator and set the state to FILL; ready_o SHALL be 0 while rst_i is high.
REQ-031 SHALL, on reset or clear during a fill or a stalled output, discard all held data; no partial word is emitted afterwards.

Structure
REQ-032 SHALL take the FSM state typedef (FILL/FULL) and the default NARROW_W/RATIO/ORDER constants from the shared package word_stack_pkg.
REQ-033 SHALL implement the output register and slot-free logic as the sub-module word_stack_slot; the accumulator and FSM stay in word_stacker.

Verification (NARROW_W=32, RATIO=4)
REQ-034 SHALL check: ORDER=0, ready_i=1, inputs AAAAAAAA, BBBBBBBB, 12345678, 55555555 back-to-back -> one cycle after the 4th accept, word_o=55555555_12345678_BBBBBBBB_AAAAAAAA, strb_o=4'hF, valid_o high for 1 cycle.
REQ-035 SHALL check: ready_i=0 while 8 words 00000001..00000008 are offered -> ready_o drops after the 8th accept (state FULL); after ready_i=1 -> 00000004_00000003_00000002_00000001 then 00000008_..._00000005 in order, no loss.
REQ-036 SHALL check: 11111111, 22222222 accepted, then flush_i for 1 cycle -> word_o=00000000_00000000_22222222_11111111, strb_o=4'b0011; flush_i with cnt=0 and valid_i=0 -> no valid_o.
REQ-037 SHALL check: ORDER=1 with the REQ-034 vectors -> word_o=AAAAAAAA_BBBBBBBB_12345678_55555555.
REQ-038 SHALL check: clr_i pulsed after 3 accepts, then FFFFFFFF×4 -> only FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF is output; rst_i asserted while valid_o is stalled high -> valid_o=0 on the next edge.

Source files
------------

// File: rtl/word_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : word_stack_pkg
// Description : Shared defaults and FSM state encoding for the word stacker.
// Revision    : 1.0 - initial release
// ============================================================================
package word_stack_pkg;

  // Default geometry: four 32-bit words stacked into one 128-bit word.
  localparam int c_narrow_w = 32;
  localparam int c_ratio    = 4;
  localparam int c_order    = 0;

  // Accumulator FSM: FILL accepts words, FULL holds a closed word that is
  // waiting for the output register to free up.
  typedef logic [0:0] state_t;
  localparam state_t c_fill = 1'b0;
  localparam state_t c_full = 1'b1;

endpackage
`default_nettype wire

// File: rtl/word_stack_slot.sv
`default_nettype none
// ============================================================================
// Module      : word_stack_slot
// Description : Output register of the word stacker. Holds one stacked word
//               with its lane strobes and reports when it can take another.
// Revision    : 1.0 - initial release
// ============================================================================
module word_stack_slot #(
  parameter int WORD_W = 128,
  parameter int STRB_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ready_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_word_i,
  input  logic [STRB_W-1:0] load_strb_i,
  output logic              free_o,
  output logic              valid_o,
  output logic [WORD_W-1:0] word_o,
  output logic [STRB_W-1:0] strb_o
);

  logic              r_valid;
  logic [WORD_W-1:0] r_word;
  logic [STRB_W-1:0] r_strb;

  // The slot can be refilled when empty or when its word leaves this cycle.
  assign free_o  = ~r_valid | ready_i;
  assign valid_o = r_valid;
  assign word_o  = r_word;
  assign strb_o  = r_strb;

  // Load a new word, otherwise drop valid once the downstream takes it.
  // Data only changes on load, so it is stable while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_strb  <= '0;
    end else if (load_i) begin
      r_valid <= 1'b1;
      r_word  <= load_word_i;
      r_strb  <= load_strb_i;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/word_stacker.sv
`default_nettype none
// ============================================================================
// Module      : word_stacker
// Description : Packs RATIO narrow input words into one wide output word,
//               with flush of partial words and per-lane strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module word_stacker
  import word_stack_pkg::*;
#(
  parameter int NARROW_W = c_narrow_w,
  parameter int RATIO    = c_ratio,
  parameter int ORDER    = c_order
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      enable_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [NARROW_W-1:0]       word_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [NARROW_W*RATIO-1:0] word_o,
  output logic [RATIO-1:0]          strb_o
);

  localparam int c_cnt_w = $clog2(RATIO);
  localparam int c_out_w = NARROW_W * RATIO;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(RATIO - 1);

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_out_w-1:0]   r_acc;
  logic [RATIO-1:0]     r_strb;

  logic                 w_clear;
  logic                 w_accept;
  logic                 w_close;
  logic                 w_free;
  logic                 w_load;
  logic [c_cnt_w-1:0]   w_lane;
  logic [c_out_w-1:0]   w_acc_next;
  logic [RATIO-1:0]     w_strb_next;
  logic [c_out_w-1:0]   w_load_word;
  logic [RATIO-1:0]     w_load_strb;

  assign w_clear  = rst_i | clr_i;
  assign ready_o  = enable_i & (r_state == c_fill) & ~rst_i & ~clr_i;
  assign w_accept = valid_i & ready_o;

  // ORDER=1 mirrors the lane sequence so the first word lands at the MSB.
  assign w_lane = (ORDER != 0) ? (c_last - r_cnt) : r_cnt;

  // Accumulator contents including any word accepted this cycle.
  always_comb begin
    w_acc_next  = r_acc;
    w_strb_next = r_strb;
    for (int k = 0; k < RATIO; k++) begin
      if (w_accept && (int'(w_lane) == k)) begin
        w_acc_next[k*NARROW_W +: NARROW_W] = word_i;
        w_strb_next[k]                     = 1'b1;
      end
    end
  end

  // A word closes when full, or on flush if it holds or receives any data.
  assign w_close = (r_state == c_fill) &
                   ((w_accept & (r_cnt == c_last)) |
                    (flush_i & enable_i & ((r_cnt != '0) | w_accept)));

  // Transfer into the output register: directly on close, or from FULL.
  assign w_load      = ~w_clear & w_free & (w_close | (r_state == c_full));
  assign w_load_word = (r_state == c_full) ? r_acc  : w_acc_next;
  assign w_load_strb = (r_state == c_full) ? r_strb : w_strb_next;

  // Fill/close state machine; a cleared accumulator keeps unfilled lanes zero.
  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      r_state <= c_fill;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_strb  <= '0;
    end else if (r_state == c_fill) begin
      if (w_close) begin
        r_cnt <= '0;
        if (w_free) begin
          r_acc  <= '0;
          r_strb <= '0;
        end else begin
          r_acc   <= w_acc_next;
          r_strb  <= w_strb_next;
          r_state <= c_full;
        end
      end else if (w_accept) begin
        r_cnt  <= r_cnt + c_cnt_w'(1);
        r_acc  <= w_acc_next;
        r_strb <= w_strb_next;
      end
    end else if (w_free) begin
      r_state <= c_fill;
      r_acc   <= '0;
      r_strb  <= '0;
    end
  end

  word_stack_slot #(
    .WORD_W (c_out_w),
    .STRB_W (RATIO)
  ) u_slot (
    .clk_i       (clk_i),
    .rst_i       (w_clear),
    .ready_i     (ready_i),
    .load_i      (w_load),
    .load_word_i (w_load_word),
    .load_strb_i (w_load_strb),
    .free_o      (w_free),
    .valid_o     (valid_o),
    .word_o      (word_o),
    .strb_o      (strb_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_word_stacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_stacker
// Description : Self-checking bench for word_stacker, ORDER=0 and ORDER=1
//               instances driven in parallel, scoreboard on the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_stacker;

  typedef struct packed {
    logic [127:0] w;
    logic [3:0]   s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         clr_i = 1'b0;
  logic         enable_i = 1'b1;
  logic         flush_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b0;
  logic [31:0]  word_i = '0;

  logic         ready0, valid0, ready1, valid1;
  logic [127:0] word0, word1;
  logic [3:0]   strb0, strb1;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] pend[$];

  always #5 clk = ~clk;

  word_stacker #(.NARROW_W(32), .RATIO(4), .ORDER(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .enable_i(enable_i),
    .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready0), .word_i(word_i),
    .valid_o(valid0), .ready_i(ready_i), .word_o(word0), .strb_o(strb0));

  word_stacker #(.NARROW_W(32), .RATIO(4), .ORDER(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .enable_i(enable_i),
    .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready1), .word_i(word_i),
    .valid_o(valid1), .ready_i(ready_i), .word_o(word1), .strb_o(strb1));

  // Scoreboard: every completed output handshake is matched against the model.
  always @(negedge clk) begin
    #2;
    if (valid0 && ready_i) begin
      total++;
      n_out++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL out0_unexpected: got word=%h strb=%h, expected no output", word0, strb0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (word0 !== e.w || strb0 !== e.s) begin
          bad++;
          $display("FAIL out0_data: got word=%h strb=%h, expected word=%h strb=%h", word0, strb0, e.w, e.s);
        end
      end
    end
    if (valid1 && ready_i) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL out1_unexpected: got word=%h strb=%h, expected no output", word1, strb1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (word1 !== e.w || strb1 !== e.s) begin
          bad++;
          $display("FAIL out1_data: got word=%h strb=%h, expected word=%h strb=%h", word1, strb1, e.w, e.s);
        end
      end
    end
  end

  // Model: closes the pending words into expected outputs for both orders.
  task automatic close_model();
    exp_t e0, e1;
    e0 = '0;
    e1 = '0;
    for (int k = 0; k < pend.size(); k++) begin
      e0.w[k*32 +: 32]     = pend[k];
      e0.s[k]              = 1'b1;
      e1.w[(3-k)*32 +: 32] = pend[k];
      e1.s[3-k]            = 1'b1;
    end
    q0.push_back(e0);
    q1.push_back(e1);
    pend.delete();
  endtask

  task automatic send(input logic [31:0] w);
    int  waited = 0;
    bit  done = 0;
    while (!done) begin
      @(negedge clk);
      valid_i = 1'b1;
      word_i  = w;
      #1;
      if (ready0) begin
        done = 1;
        pend.push_back(w);
        if (pend.size() == 4) close_model();
      end else if (++waited > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got ready_o=0 for 50 cycles, expected accept of %h", w);
        done = 1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b0;
    clr_i   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d words still pending, expected 0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (valid0 !== 1'b0 || word0 !== '0 || strb0 !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b word=%h strb=%h, expected 0", valid0, word0, strb0);
    end
    total++;
    if (ready0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got ready_o=%b, expected 0", ready0);
    end
    rst_i = 1'b0;
    #1;
    total++;
    if (ready0 !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got ready_o=%b, expected 1", ready0);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    ready_i = 1'b1;
    send(32'hAAAAAAAA);
    send(32'hBBBBBBBB);
    send(32'h12345678);
    send(32'h55555555);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    total++;
    if (valid0 !== 1'b1 || word0 !== 128'h55555555_12345678_BBBBBBBB_AAAAAAAA || strb0 !== 4'hF) begin
      bad++;
      $display("FAIL basic_order0: got valid=%b word=%h strb=%h, expected 1 55555555_12345678_BBBBBBBB_AAAAAAAA f", valid0, word0, strb0);
    end
    total++;
    if (word1 !== 128'hAAAAAAAA_BBBBBBBB_12345678_55555555) begin
      bad++;
      $display("FAIL basic_order1: got word=%h, expected AAAAAAAA_BBBBBBBB_12345678_55555555", word1);
    end
    @(negedge clk);
    #1;
    total++;
    if (valid0 !== 1'b0) begin
      bad++;
      $display("FAIL basic_one_cycle: got valid_o=%b, expected 0", valid0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int start = n_out;
    for (int i = 0; i < 8; i++) send(32'hC0DE0000 + 32'(i));
    idle();
    drain();
    total++;
    if (n_out - start != 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d outputs, expected 2", n_out - start);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) send(32'(i));
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    total++;
    if (ready0 !== 1'b0) begin
      bad++;
      $display("FAIL stall_ready: got ready_o=%b, expected 0", ready0);
    end
    total++;
    if (word0 !== 128'h00000004_00000003_00000002_00000001 || strb0 !== 4'hF) begin
      bad++;
      $display("FAIL stall_hold: got word=%h strb=%h, expected 00000004_00000003_00000002_00000001 f", word0, strb0);
    end
    ready_i = 1'b1;
    drain();
  endtask

  task automatic test_flush();
    send(32'h11111111);
    send(32'h22222222);
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b1;
    close_model();
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    total++;
    if (valid0 !== 1'b1 || word0 !== 128'h00000000_00000000_22222222_11111111 || strb0 !== 4'b0011) begin
      bad++;
      $display("FAIL flush_partial: got valid=%b word=%h strb=%b, expected 1 0_0_22222222_11111111 0011", valid0, word0, strb0);
    end
    total++;
    if (word1 !== 128'h11111111_22222222_00000000_00000000 || strb1 !== 4'b1100) begin
      bad++;
      $display("FAIL flush_partial1: got word=%h strb=%b, expected 11111111_22222222_0_0 1100", word1, strb1);
    end
    drain();
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (valid0 !== 1'b0) begin
        bad++;
        $display("FAIL flush_empty: got valid_o=%b, expected 0", valid0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clear();
    send(32'h01010101);
    send(32'h02020202);
    send(32'h03030303);
    @(negedge clk);
    valid_i = 1'b0;
    clr_i   = 1'b1;
    pend.delete();
    #1;
    total++;
    if (ready0 !== 1'b0) begin
      bad++;
      $display("FAIL clear_ready: got ready_o=%b, expected 0", ready0);
    end
    idle();
    for (int i = 0; i < 4; i++) send(32'hFFFFFFFF);
    idle();
    drain();
  endtask

  task automatic test_reset_stall();
    @(negedge clk);
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hDEAD0000 + 32'(i));
    idle();
    #1;
    total++;
    if (valid0 !== 1'b1) begin
      bad++;
      $display("FAIL rst_stall_pre: got valid_o=%b, expected 1", valid0);
    end
    rst_i = 1'b1;
    q0.delete();
    q1.delete();
    pend.delete();
    @(negedge clk);
    #1;
    total++;
    if (valid0 !== 1'b0 || strb0 !== 4'h0 || word0 !== '0) begin
      bad++;
      $display("FAIL rst_stall_post: got valid=%b word=%h strb=%h, expected 0", valid0, word0, strb0);
    end
    rst_i   = 1'b0;
    ready_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_enable();
    @(negedge clk);
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hE0000000 + 32'(i));
    @(negedge clk);
    enable_i = 1'b0;
    valid_i  = 1'b1;
    word_i   = 32'h99999999;
    #1;
    total++;
    if (ready0 !== 1'b0) begin
      bad++;
      $display("FAIL enable_ready: got ready_o=%b, expected 0", ready0);
    end
    ready_i = 1'b1;
    drain();
    valid_i = 1'b0;
    @(negedge clk);
    enable_i = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_flush();
    test_clear();
    test_reset_stall();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
